// File: rtl/dedo_tracker_if.sv
// Fingertip tracker bus: detector-side frame sample in, filtered cursor position out.
interface dedo_tracker_if;
    logic        frame_sync;
    logic [19:0] detect_pos_pixel;
    logic        achou;
    logic [10:0] x;
    logic [10:0] y;
    logic        valid;
    logic        upd;

    modport master (
        output frame_sync, detect_pos_pixel, achou,
        input  x, y, valid, upd
    );

    modport slave (
        input  frame_sync, detect_pos_pixel, achou,
        output x, y, valid, upd
    );
endinterface

// File: rtl/dedo_tracker.sv
// Turns a per-frame linear fingertip index into a smoothed x/y cursor with
// found/lost hysteresis; row/column split is a 9-step restoring divider.
module dedo_tracker #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int SHIFT        = 2,
    parameter int FOUND_FRAMES = 2,
    parameter int LOST_FRAMES  = 8
) (
    input  logic           clk,
    input  logic           reset,
    dedo_tracker_if.slave  bus
);
    localparam int FCW = $clog2(FOUND_FRAMES + 1);
    localparam int LCW = $clog2(LOST_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FILT, S_UPD} state_t;

    state_t          state_q, state_d;
    logic            fs_s1_q, fs_s2_q, fs_s3_q;
    logic            fs_edge;
    logic [3:0]      k_q, k_d;
    logic [19:0]     rem_q, rem_d;
    logic [8:0]      quo_q, quo_d;
    logic            f_raw_q, f_raw_d;
    logic            found_q, found_d;
    logic [10:0]     ema_x_q, ema_x_d, ema_y_q, ema_y_d;
    logic [10:0]     x_q, x_d, y_q, y_d;
    logic            valid_q, valid_d, upd_q, upd_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [LCW-1:0]  lcnt_q, lcnt_d;
    logic [20:0]     dvs;
    logic            rem_ge;

    // One EMA step; the sum can never go negative, the guard only keeps bit 11 meaningful.
    function automatic logic [10:0] ema_step(input logic [10:0] cur, input logic [10:0] raw);
        logic signed [11:0] d, step, nxt;
        d    = $signed({1'b0, raw}) - $signed({1'b0, cur});
        step = d >>> SHIFT;
        nxt  = $signed({1'b0, cur}) + step;
        return nxt[11] ? 11'd0 : nxt[10:0];
    endfunction

    assign fs_edge = fs_s2_q & ~fs_s3_q;
    assign dvs     = 21'(WIDTH) << k_q;
    assign rem_ge  = {1'b0, rem_q} >= dvs;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        f_raw_d = f_raw_q;
        found_d = found_q;
        ema_x_d = ema_x_q;
        ema_y_d = ema_y_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        fcnt_d  = fcnt_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            S_IDLE: begin
                if (fs_edge) begin
                    rem_d   = bus.detect_pos_pixel;
                    f_raw_d = bus.achou;
                    quo_d   = '0;
                    k_d     = 4'd8;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (rem_ge) begin
                    rem_d = rem_q - dvs[19:0];
                    quo_d = quo_q | (9'd1 << k_q);
                end
                if (k_q == 4'd0) state_d = S_FILT;
                else             k_d     = k_q - 4'd1;
            end
            S_FILT: begin
                // rem < WIDTH is implied whenever quo < HEIGHT; kept as a cheap sanity guard.
                found_d = f_raw_q && ({2'b0, quo_q} < 11'(HEIGHT)) && (rem_q < 20'(WIDTH));
                ema_x_d = ema_step(x_q, rem_q[10:0]);
                ema_y_d = ema_step(y_q, {2'b0, quo_q});
                state_d = S_UPD;
            end
            S_UPD: begin
                if (found_q) begin
                    lcnt_d = '0;
                    if (fcnt_q != FCW'(FOUND_FRAMES)) fcnt_d = fcnt_q + 1'b1;
                end else begin
                    fcnt_d = '0;
                    if (lcnt_q != LCW'(LOST_FRAMES)) lcnt_d = lcnt_q + 1'b1;
                end
                if (!valid_q && fcnt_d == FCW'(FOUND_FRAMES)) begin
                    valid_d = 1'b1;
                    x_d     = rem_q[10:0];
                    y_d     = {2'b0, quo_q};
                end else if (valid_q && found_q) begin
                    x_d = ema_x_q;
                    y_d = ema_y_q;
                end else if (valid_q && lcnt_d == LCW'(LOST_FRAMES)) begin
                    valid_d = 1'b0;
                end
                upd_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            fs_s1_q <= 1'b0;
            fs_s2_q <= 1'b0;
            fs_s3_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            fcnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            fs_s1_q <= bus.frame_sync;
            fs_s2_q <= fs_s1_q;
            fs_s3_q <= fs_s2_q;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            fcnt_q  <= fcnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Datapath registers are always overwritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        f_raw_q <= f_raw_d;
        found_q <= found_d;
        ema_x_q <= ema_x_d;
        ema_y_q <= ema_y_d;
    end

    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.valid = valid_q;
    assign bus.upd   = upd_q;
endmodule

// File: tb/tb_dedo_tracker.sv
// Bench for dedo_tracker: directed scenarios plus random frames against a frame-level model.
module tb_dedo_tracker;
    localparam int WIDTH = 640, HEIGHT = 480, SHIFT = 2, FF = 2, LF = 8;
    localparam int LAT = 14; // rise sampled -> 2 sync edges -> latch edge E -> upd at E+11

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dedo_tracker_if bus ();

    dedo_tracker #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .SHIFT(SHIFT),
                   .FOUND_FRAMES(FF), .LOST_FRAMES(LF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int m_x, m_y, m_fc, m_lc;
    bit m_valid;

    function automatic int ema(input int cur, input int raw);
        int d, s, div;
        div = 1 << SHIFT;
        d   = raw - cur;
        if (d >= 0) s = d / div;
        else        s = -((-d + div - 1) / div);
        return cur + s;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_fc = 0; m_lc = 0; m_valid = 0;
    endtask

    task automatic model_frame(input int pos, input bit ach);
        int row, col;
        bit f;
        row = pos / WIDTH;
        col = pos % WIDTH;
        f   = ach && (row < HEIGHT);
        if (f) begin m_lc = 0; if (m_fc < FF) m_fc++; end
        else   begin m_fc = 0; if (m_lc < LF) m_lc++; end
        if (!m_valid && m_fc >= FF) begin
            m_valid = 1; m_x = col; m_y = row;
        end else if (m_valid && f) begin
            m_x = ema(m_x, col); m_y = ema(m_y, row);
        end else if (m_valid && m_lc >= LF) begin
            m_valid = 0;
        end
    endtask

    task automatic do_reset();
        bus.frame_sync = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Runs one frame from a negedge; lat = posedges from rise to first upd (-1 on timeout).
    task automatic do_frame(input int pos, input bit ach, output int lat, output logic upd_after);
        bus.detect_pos_pixel = pos[19:0];
        bus.achou            = ach;
        bus.frame_sync       = 1'b1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.upd === 1'b1) begin lat = c; break; end
        end
        model_frame(pos, ach);
        @(negedge clk);
        upd_after = bus.upd;
        bus.frame_sync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int lat, pulses;
        logic ua;
        do_reset();
        total++;
        if ({bus.x, bus.y, bus.valid, bus.upd} !== 24'h0) begin
            bad++; $display("FAIL reset_state: got x=%0d y=%0d v=%b u=%b want all 0", bus.x, bus.y, bus.valid, bus.upd);
        end
        do_frame(641, 1, lat, ua);
        do_frame(641, 1, lat, ua);
        total++;
        if (bus.valid !== 1'b1) begin bad++; $display("FAIL reset_preacq: valid=%b want 1", bus.valid); end
        bus.detect_pos_pixel = 20'd1000;
        bus.achou = 1'b1;
        bus.frame_sync = 1'b1;
        repeat (8) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.x, bus.y, bus.valid, bus.upd} !== 24'h0) begin
            bad++; $display("FAIL reset_middiv: got x=%0d y=%0d v=%b u=%b want all 0", bus.x, bus.y, bus.valid, bus.upd);
        end
        model_reset();
        bus.frame_sync = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (30) begin @(negedge clk); if (bus.upd === 1'b1) pulses++; end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL reset_noupd: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_acquire_corner();
        int lat;
        logic ua;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            do_frame(307199, 1, lat, ua);
            total++;
            if (lat !== LAT) begin bad++; $display("FAIL corner_lat%0d: got %0d want %0d", i, lat, LAT); end
            total++;
            if (ua !== 1'b0) begin bad++; $display("FAIL corner_updwidth%0d: upd still %b next cycle want 0", i, ua); end
            total++;
            if (bus.valid !== (i == 1)) begin bad++; $display("FAIL corner_valid%0d: got %b want %0d", i, bus.valid, i == 1); end
        end
        total++;
        if (bus.x !== 11'd639 || bus.y !== 11'd479) begin
            bad++; $display("FAIL corner_xy: got %0d,%0d want 639,479", bus.x, bus.y);
        end
    endtask

    task automatic test_smoothing();
        int lat;
        logic ua;
        int exp_x[3] = '{100, 175, 231};
        do_reset();
        do_frame(0, 1, lat, ua);
        do_frame(0, 1, lat, ua);
        for (int i = 0; i < 3; i++) begin
            do_frame(400, 1, lat, ua);
            total++;
            if (bus.x !== 11'(exp_x[i]) || bus.x !== 11'(m_x) || bus.y !== 11'd0 || bus.valid !== 1'b1) begin
                bad++; $display("FAIL smooth%0d: got x=%0d y=%0d v=%b want x=%0d y=0 v=1", i, bus.x, bus.y, bus.valid, exp_x[i]);
            end
        end
    endtask

    task automatic test_dropout();
        int lat;
        logic ua;
        do_reset();
        do_frame(153920, 1, lat, ua);
        do_frame(153920, 1, lat, ua);
        total++;
        if (bus.x !== 11'd320 || bus.y !== 11'd240 || bus.valid !== 1'b1) begin
            bad++; $display("FAIL drop_acq: got x=%0d y=%0d v=%b want 320,240,1", bus.x, bus.y, bus.valid);
        end
        for (int i = 1; i <= 8; i++) begin
            do_frame($urandom_range(0, 307199), 0, lat, ua);
            total++;
            if (bus.x !== 11'd320 || bus.y !== 11'd240 || bus.valid !== (i < 8)) begin
                bad++; $display("FAIL drop%0d: got x=%0d y=%0d v=%b want 320,240,%0d", i, bus.x, bus.y, bus.valid, i < 8);
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic ua;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_frame(307200, 1, lat, ua);
            total++;
            if (lat !== LAT || bus.valid !== 1'b0) begin
                bad++; $display("FAIL oor%0d: got lat=%0d v=%b want lat=%0d v=0", i, lat, bus.valid, LAT);
            end
        end
    endtask

    task automatic test_busy_edge();
        int lat, pulses, first;
        logic ua;
        do_reset();
        bus.detect_pos_pixel = 20'd641;
        bus.achou = 1'b1;
        bus.frame_sync = 1'b1;
        pulses = 0;
        first = -1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 5) bus.frame_sync = 1'b0;
            if (c == 7) bus.frame_sync = 1'b1;
            if (bus.upd === 1'b1) begin pulses++; if (first < 0) first = c; end
        end
        bus.frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        model_frame(641, 1);
        total++;
        if (pulses !== 1 || first !== LAT) begin
            bad++; $display("FAIL busy_pulses: got %0d pulses first at %0d want 1 at %0d", pulses, first, LAT);
        end
        do_frame(641, 1, lat, ua);
        do_frame(641, 1, lat, ua);
        total++;
        if (bus.x !== 11'd1 || bus.y !== 11'd1 || bus.valid !== 1'b1) begin
            bad++; $display("FAIL busy_after: got x=%0d y=%0d v=%b want 1,1,1", bus.x, bus.y, bus.valid);
        end
    endtask

    task automatic test_random();
        int lat, pos;
        logic ua;
        bit ach;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            ach = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) pos = int'($urandom_range(307200, 1048575));
            else                           pos = int'($urandom_range(0, 307199));
            do_frame(pos, ach, lat, ua);
            total++;
            if (lat !== LAT || ua !== 1'b0) begin
                bad++; $display("FAIL rand_timing%0d: got lat=%0d upd_next=%b want %0d,0", i, lat, ua, LAT);
            end
            total++;
            if (bus.x !== 11'(m_x) || bus.y !== 11'(m_y) || bus.valid !== m_valid) begin
                bad++; $display("FAIL rand_out%0d pos=%0d ach=%0d: got x=%0d y=%0d v=%b want x=%0d y=%0d v=%0d",
                                i, pos, ach, bus.x, bus.y, bus.valid, m_x, m_y, m_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_sync = 1'b0;
        bus.detect_pos_pixel = '0;
        bus.achou = 1'b0;
        model_reset();
        test_reset();
        test_acquire_corner();
        test_smoothing();
        test_dropout();
        test_out_of_range();
        test_busy_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
